// File: rtl/nrammux_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : nrammux_pkg
//  Purpose : Shared types and constants for the NRAMMUX access arbiter.
//            req_t      - one requester's command {write, addr, wdata}
//            rsp_pipe_t - one read-response pipeline slot {valid, id, addr}
//            next_id()  - round-robin successor of a requester index
//  Rev     : 1.0  initial release
// ============================================================================
package nrammux_pkg;

    localparam int NREQ_MAX = 4;
    localparam int AW_DEF   = 2;
    localparam int DW_DEF   = 8;
    localparam int ID_W     = 2;   // wide enough for NREQ_MAX requesters

    typedef struct packed {
        logic              write;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [AW_DEF-1:0] addr;
    } rsp_pipe_t;

    // Successor of requester 'id' in a ring of n requesters.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int n);
        return (int'(id) == n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrammux_arbiter_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Purpose : NREQ-wide round-robin pick with pointer update.
//  Ports   : clk        in   clock
//            reset      in   asynchronous active-low reset
//            valid      in   NREQ request bits (already qualified)
//            grant      out  one-hot grant (combinational)
//            grant_id   out  index of the granted requester
//            grant_any  out  1 when any requester is granted
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter
    import nrammux_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_any
);

    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] sel;
    int              idx;

    // Scan the ring starting at ptr; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = NREQ'(1) << idx;
            if (!grant_any && (|(valid & sel))) begin
                grant_any = 1'b1;
                grant     = sel;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= next_id(grant_id, NREQ);
        end
    end

endmodule
`default_nettype wire

// File: rtl/nrammux_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : nrammux_arbiter
//  Purpose : Round-robin arbiter sharing the NRAMMUX write and read ports
//            among NREQ requesters, with a fixed-latency read response and a
//            write-to-read bypass so a read returns the data as of its grant.
//  Ports   : clk, reset (async active-low)
//            io_req_valid/write/addr/wdata  in   request channel
//            io_req_ready                   out  one-hot grant
//            io_rsp_valid / io_rsp_data     out  read response
//            io_WE, io_WADD, io_D, io_RADD  out  RAM control
//            io_Q                           in   RAM read data (RD_LAT later)
//  Rev     : 1.0  initial release
// ============================================================================
module nrammux_arbiter
    import nrammux_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    io_req_valid,
    input  logic [NREQ-1:0]    io_req_write,
    input  logic [NREQ*AW-1:0] io_req_addr,
    input  logic [NREQ*DW-1:0] io_req_wdata,
    output logic [NREQ-1:0]    io_req_ready,
    output logic [NREQ-1:0]    io_rsp_valid,
    output logic [DW-1:0]      io_rsp_data,
    output logic               io_WE,
    output logic [AW-1:0]      io_WADD,
    output logic [DW-1:0]      io_D,
    output logic [AW-1:0]      io_RADD,
    input  logic [DW-1:0]      io_Q
);

    req_t            req [NREQ];
    req_t            sel_req;
    logic            run;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_any;
    logic            wr_grant;
    logic            rd_grant;
    logic [AW-1:0]   radd_q;

    // Newest write, kept so a read can be served before the RAM shows it.
    logic            byp_valid;
    logic [AW-1:0]   byp_addr;
    logic [DW-1:0]   byp_data;

    // Response pipe plus a snapshot of the bypass register taken at grant.
    rsp_pipe_t       pipe       [RD_LAT];
    logic            cand_valid [RD_LAT];
    logic [AW-1:0]   cand_addr  [RD_LAT];
    logic [DW-1:0]   cand_data  [RD_LAT];
    rsp_pipe_t       rsp_head;
    logic            byp_hit;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req[i] = {io_req_write[i], io_req_addr[i*AW +: AW], io_req_wdata[i*DW +: DW]};
    end

    // Grants start on the first edge after reset release, so reset is
    // never used as a combinational data signal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .valid     (io_req_valid & {NREQ{run}}),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_req = req[i];
            end
        end
    end

    assign wr_grant     = grant_any &  sel_req.write;
    assign rd_grant     = grant_any & ~sel_req.write;
    assign io_req_ready = grant;
    assign io_WE        = wr_grant;
    assign io_WADD      = wr_grant ? sel_req.addr  : '0;
    assign io_D         = wr_grant ? sel_req.wdata : '0;
    assign io_RADD      = rd_grant ? sel_req.addr  : radd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            radd_q    <= '0;
            byp_valid <= 1'b0;
            byp_addr  <= '0;
            byp_data  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe[s]       <= '0;
                cand_valid[s] <= 1'b0;
                cand_addr[s]  <= '0;
                cand_data[s]  <= '0;
            end
        end else begin
            if (rd_grant) begin
                radd_q <= sel_req.addr;
            end
            if (wr_grant) begin
                byp_valid <= 1'b1;
                byp_addr  <= sel_req.addr;
                byp_data  <= sel_req.wdata;
            end
            pipe[0]       <= '{valid: rd_grant, id: grant_id, addr: sel_req.addr};
            cand_valid[0] <= byp_valid;
            cand_addr[0]  <= byp_addr;
            cand_data[0]  <= byp_data;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe[s]       <= pipe[s-1];
                cand_valid[s] <= cand_valid[s-1];
                cand_addr[s]  <= cand_addr[s-1];
                cand_data[s]  <= cand_data[s-1];
            end
        end
    end

    // The snapshot is the newest write granted before this read; if it hit
    // the same address it is the correct data whether or not the RAM has
    // committed it yet.
    assign rsp_head     = pipe[RD_LAT-1];
    assign byp_hit      = cand_valid[RD_LAT-1] && (cand_addr[RD_LAT-1] == rsp_head.addr);
    assign io_rsp_valid = rsp_head.valid ? (NREQ'(1) << rsp_head.id) : '0;
    assign io_rsp_data  = !rsp_head.valid ? '0 :
                          byp_hit         ? cand_data[RD_LAT-1] : io_Q;

endmodule
`default_nettype wire

// File: tb/tb_nrammux_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_nrammux_arbiter
//  Purpose : Self-checking bench for nrammux_arbiter (NREQ=4, RD_LAT=2).
//            A RAM with a posted (one-cycle-late) write sits on the RAM port,
//            so back-to-back write/read needs the bypass.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_nrammux_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 2;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    io_req_valid = '0;
    logic [NREQ-1:0]    io_req_write = '0;
    logic [NREQ*AW-1:0] io_req_addr  = '0;
    logic [NREQ*DW-1:0] io_req_wdata = '0;
    logic [NREQ-1:0]    io_req_ready;
    logic [NREQ-1:0]    io_rsp_valid;
    logic [DW-1:0]      io_rsp_data;
    logic               io_WE;
    logic [AW-1:0]      io_WADD;
    logic [DW-1:0]      io_D;
    logic [AW-1:0]      io_RADD;
    logic [DW-1:0]      io_Q;

    always #5 clk = ~clk;

    nrammux_arbiter #(
        .NREQ         (NREQ),
        .AW           (AW),
        .DW           (DW),
        .RD_LAT       (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_write (io_req_write),
        .io_req_addr  (io_req_addr),
        .io_req_wdata (io_req_wdata),
        .io_req_ready (io_req_ready),
        .io_rsp_valid (io_rsp_valid),
        .io_rsp_data  (io_rsp_data),
        .io_WE        (io_WE),
        .io_WADD      (io_WADD),
        .io_D         (io_D),
        .io_RADD      (io_RADD),
        .io_Q         (io_Q)
    );

    // RAM: write lands one edge late; read data two edges after address.
    logic [DW-1:0] ram [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic          pw_v = 1'b0;
    logic [AW-1:0] pw_a = '0;
    logic [DW-1:0] pw_d = '0;
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;

    always @(posedge clk) begin
        if (pw_v) ram[pw_a] <= pw_d;
        pw_v <= io_WE;
        pw_a <= io_WADD;
        pw_d <= io_D;
        q1   <= ram[io_RADD];
        q2   <= q1;
    end
    assign io_Q = q2;

    // Reference model: architectural memory, ring pointer, expected responses.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0]   ref_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_t            pend[$];
    int              ref_ptr    = 0;
    bit              armed      = 1'b0;
    int              cyc        = 0;
    logic [AW-1:0]   last_radd  = '0;
    logic [NREQ-1:0] last_grant = '0;
    int              errors     = 0;
    int              checks     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] erv;
        logic [DW-1:0]   erd;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        logic [AW-1:0]   eradd;
        bit              ew;
        bit              exp_any;
        int              exp_id;
        int              cand;
        @(negedge clk);
        exp_any = 1'b0;
        exp_id  = 0;
        eg      = '0;
        if (reset && armed) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (ref_ptr + k) % NREQ;
                if (!exp_any && io_req_valid[cand]) begin
                    exp_any = 1'b1;
                    exp_id  = cand;
                end
            end
        end
        if (exp_any) eg[exp_id] = 1'b1;
        ew    = exp_any && io_req_write[exp_id];
        ea    = io_req_addr[exp_id*AW +: AW];
        ed    = io_req_wdata[exp_id*DW +: DW];
        eradd = !reset ? '0 : (exp_any && !ew) ? ea : last_radd;
        erv   = '0;
        erd   = '0;
        if (reset && pend.size() > 0 && pend[0].due == cyc) begin
            erv[pend[0].id] = 1'b1;
            erd             = pend[0].data;
        end
        chk("ready",     32'(io_req_ready), 32'(eg));
        chk("we",        32'(io_WE),        32'(ew));
        chk("wadd",      32'(io_WADD),      32'(ew ? ea : '0));
        chk("wdata",     32'(io_D),         32'(ew ? ed : '0));
        chk("radd",      32'(io_RADD),      32'(eradd));
        chk("rsp_valid", 32'(io_rsp_valid), 32'(erv));
        chk("rsp_data",  32'(io_rsp_data),  32'(erd));
        last_grant = eg;
        @(posedge clk);
        if (!reset) begin
            ref_ptr   = 0;
            armed     = 1'b0;
            last_radd = '0;
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (exp_any) begin
                ref_ptr = (exp_id + 1) % NREQ;
                if (ew) begin
                    ref_mem[ea] = ed;
                end else begin
                    pend.push_back('{cyc + RD_LAT, exp_id, ref_mem[ea]});
                    last_radd = ea;
                end
            end
            armed = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input int d);
        io_req_valid[i]          = v;
        io_req_write[i]          = w;
        io_req_addr[i*AW +: AW]  = AW'(a);
        io_req_wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic clear_reqs();
        io_req_valid = '0;
        io_req_write = '0;
        io_req_addr  = '0;
        io_req_wdata = '0;
    endtask

    // A requester still waiting for its grant keeps its command unchanged.
    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (!(io_req_valid[i] && !last_grant[i])) begin
                io_req_valid[i]          = ($urandom_range(0, 99) < 55);
                io_req_write[i]          = 1'($urandom_range(0, 1));
                io_req_addr[i*AW +: AW]  = AW'($urandom_range(0, 3));
                io_req_wdata[i*DW +: DW] = DW'($urandom());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Single write then read of the same address
        set_req(0, 1, 1, 2, 8'hA5);
        step();
        set_req(0, 1, 0, 2, 0);
        step();
        clear_reqs();
        repeat (3) step();

        // Two readers in contention
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 3, 0);
        repeat (8) step();
        clear_reqs();
        repeat (3) step();

        // Read right after a write to the same address (bypass)
        set_req(1, 1, 1, 0, 8'h3C);
        step();
        clear_reqs();
        set_req(0, 1, 0, 0, 0);
        step();
        clear_reqs();
        repeat (3) step();

        // Pointer wrap: move pointer to 3, then requesters 3 and 0 compete
        set_req(2, 1, 1, 1, 8'h5A);
        step();
        clear_reqs();
        set_req(3, 1, 0, 1, 0);
        set_req(0, 1, 0, 3, 0);
        repeat (6) step();
        clear_reqs();
        repeat (3) step();

        // Idle
        repeat (10) step();

        // Reset with a read in flight
        set_req(1, 1, 0, 2, 0);
        step();
        clear_reqs();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (5) step();

        // Randomized traffic
        repeat (400) begin
            drive_random();
            step();
        end
        clear_reqs();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
